// File: rtl/wishbone_sram_slave.sv
// wishbone_sram_slave: Wishbone classic slave over a byte-writable synchronous word RAM with wait states and out-of-window error.
module wishbone_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH = 4,
  parameter int MEM_AW = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wishbone_cyc_i,
  input  logic                  wishbone_stb_i,
  input  logic                  wishbone_we_i,
  input  logic [ADDR_WIDTH-1:0] wishbone_addr_i,
  input  logic [DATA_WIDTH-1:0] wishbone_data_i,
  input  logic [SEL_WIDTH-1:0]  wishbone_sel_i,
  output logic [DATA_WIDTH-1:0] wishbone_data_o,
  output logic                  wishbone_ack_o,
  output logic                  wishbone_err_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic ack_r, err_r, req, hit, commit, unused_ok;
  logic [MEM_AW-1:0] idx;
  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
  assign req = wishbone_cyc_i & wishbone_stb_i;
  assign hit = wishbone_addr_i[ADDR_WIDTH-1:MEM_AW+2] == BASE_ADDR[ADDR_WIDTH-1:MEM_AW+2];
  assign idx = wishbone_addr_i[MEM_AW+1:2];
  assign unused_ok = &{1'b0, wishbone_addr_i[1:0]};
  assign wishbone_ack_o = ack_r & req;
  assign wishbone_err_o = err_r & req;
  // commit marks the edge that enters S_RESP; that edge samples the bus
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    commit = 1'b0;
    case (state)
      S_IDLE:
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = S_RESP;
            commit = 1'b1;
          end else begin
            state_nx = S_WAIT;
            cnt_nx = 4'(WAIT_CYCLES - 1);
          end
        end
      S_WAIT:
        if (!req) state_nx = S_IDLE;
        else if (cnt == '0) begin
          state_nx = S_RESP;
          commit = 1'b1;
        end else cnt_nx = cnt - 4'd1;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      ack_r <= 1'b0;
      err_r <= 1'b0;
      wishbone_data_o <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ack_r <= commit & hit;
      err_r <= commit & !hit;
      if (commit && hit && !wishbone_we_i) wishbone_data_o <= mem[idx];
    end
  end
  // RAM contents survive reset; writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && commit && hit && wishbone_we_i)
      for (int i = 0; i < SEL_WIDTH; i++)
        if (wishbone_sel_i[i]) mem[idx][8*i +: 8] <= wishbone_data_i[8*i +: 8];
  end
endmodule

// File: tb/tb_wishbone_sram_slave.sv
// tb_wishbone_sram_slave: directed checks of a zero-wait and a three-wait instance sharing address/data lines.
module tb_wishbone_sram_slave;
  logic clk = 1'b0, rst_n = 1'b0;
  logic we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] sel = '0;
  logic cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
  logic [31:0] rd0, rd3;
  logic ack0, err0, ack3, err3;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;

  wishbone_sram_slave #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wishbone_cyc_i(cyc0), .wishbone_stb_i(stb0),
    .wishbone_we_i(we), .wishbone_addr_i(addr), .wishbone_data_i(wdata),
    .wishbone_sel_i(sel), .wishbone_data_o(rd0), .wishbone_ack_o(ack0),
    .wishbone_err_o(err0));
  wishbone_sram_slave #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .wishbone_cyc_i(cyc3), .wishbone_stb_i(stb3),
    .wishbone_we_i(we), .wishbone_addr_i(addr), .wishbone_data_i(wdata),
    .wishbone_sel_i(sel), .wishbone_data_o(rd3), .wishbone_ack_o(ack3),
    .wishbone_err_o(err3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit d3, input logic v);
    if (d3) begin cyc3 = v; stb3 = v; end
    else begin cyc0 = v; stb0 = v; end
  endtask

  // Drives one transfer and waits (bounded) for ack or err; lat = -1 on timeout.
  task automatic xfer(input bit d3, input logic w, input logic [31:0] a, d, input logic [3:0] s,
                      output int lat, output logic ack, output logic err, output logic [31:0] rd);
    we = w; addr = a; wdata = d; sel = s;
    set_req(d3, 1'b1);
    lat = -1; ack = 1'b0; err = 1'b0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (d3 ? (ack3 | err3) : (ack0 | err0)) begin
        lat = i; ack = d3 ? ack3 : ack0; err = d3 ? err3 : err0; rd = d3 ? rd3 : rd0;
        break;
      end
    end
    set_req(d3, 1'b0);
    tick();
  endtask

  task automatic test_reset;
    tick();
    n_cmp++; if ({ack0, err0, ack3, err3} !== 4'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0000", {ack0, err0, ack3, err3}); end
    n_cmp++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_data0: got %h want 00000000", rd0); end
    n_cmp++; if (rd3 !== 32'h0) begin n_fail++; $display("FAIL reset_data3: got %h want 00000000", rd3); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int lat; logic a, e; logic [31:0] r;
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, a, e, r);
    n_cmp++; if (lat !== 1 || a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL basic_wr: lat %0d ack %b err %b want 1 1 0", lat, a, e); end
    n_cmp++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL basic_data_before_read: got %h want 00000000", rd0); end
    xfer(0, 0, 32'h10, 32'h0, 4'h0, lat, a, e, r);
    n_cmp++; if (lat !== 1 || a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL basic_rd: lat %0d ack %b err %b want 1 1 0", lat, a, e); end
    n_cmp++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data: got %h want deadbeef", r); end
  endtask

  task automatic test_byte_lanes;
    int lat; logic a, e; logic [31:0] r;
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, lat, a, e, r);
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, a, e, r);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, lat, a, e, r);
    n_cmp++; if (r !== 32'h11BB33DD) begin n_fail++; $display("FAIL lanes_0101: got %h want 11bb33dd", r); end
    xfer(0, 1, 32'h22, 32'hFFFFFFFF, 4'b0000, lat, a, e, r);
    n_cmp++; if (lat !== 1 || a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL lanes_sel0_ack: lat %0d ack %b err %b want 1 1 0", lat, a, e); end
    n_cmp++; if (rd0 !== 32'h11BB33DD) begin n_fail++; $display("FAIL lanes_write_keeps_data_o: got %h want 11bb33dd", rd0); end
    xfer(0, 0, 32'h20, 32'h0, 4'h0, lat, a, e, r);
    n_cmp++; if (r !== 32'h11BB33DD) begin n_fail++; $display("FAIL lanes_sel0_unchanged: got %h want 11bb33dd", r); end
  endtask

  task automatic test_wait_states;
    int lat; logic a, e; logic [31:0] r;
    xfer(1, 1, 32'h40, 32'hCAFEF00D, 4'hF, lat, a, e, r);
    n_cmp++; if (lat !== 4 || a !== 1'b1) begin n_fail++; $display("FAIL wait_wr: lat %0d ack %b want 4 1", lat, a); end
    we = 1'b0; addr = 32'h40; set_req(1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if ({ack3, err3} !== 2'b00) begin n_fail++; $display("FAIL wait_quiet_%0d: ack/err %b want 00", i, {ack3, err3}); end
    end
    tick();
    n_cmp++; if ({ack3, err3} !== 2'b10) begin n_fail++; $display("FAIL wait_ack: ack/err %b want 10", {ack3, err3}); end
    n_cmp++; if (rd3 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wait_rd_data: got %h want cafef00d", rd3); end
    set_req(1, 1'b0);
    tick();
  endtask

  task automatic test_abort;
    int lat; logic a, e; logic [31:0] r;
    we = 1'b1; addr = 32'h40; wdata = 32'h12345678; sel = 4'hF; set_req(1, 1'b1);
    tick(); tick();
    set_req(1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if ({ack3, err3} !== 2'b00) begin n_fail++; $display("FAIL abort_quiet_%0d: ack/err %b want 00", i, {ack3, err3}); end
    end
    xfer(1, 0, 32'h40, 32'h0, 4'h0, lat, a, e, r);
    n_cmp++; if (lat !== 4 || a !== 1'b1) begin n_fail++; $display("FAIL abort_next: lat %0d ack %b want 4 1", lat, a); end
    n_cmp++; if (r !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_ram: got %h want cafef00d", r); end
  endtask

  task automatic test_out_of_window;
    int lat; logic a, e; logic [31:0] r;
    xfer(0, 1, 32'h4, 32'h55AA55AA, 4'hF, lat, a, e, r);
    xfer(0, 0, 32'h1000, 32'h0, 4'h0, lat, a, e, r);
    n_cmp++; if (lat !== 1 || a !== 1'b0 || e !== 1'b1) begin n_fail++; $display("FAIL oow_rd: lat %0d ack %b err %b want 1 0 1", lat, a, e); end
    n_cmp++; if (r !== 32'h11BB33DD) begin n_fail++; $display("FAIL oow_data_hold: got %h want 11bb33dd", r); end
    xfer(0, 1, 32'h1004, 32'hFFFFFFFF, 4'hF, lat, a, e, r);
    n_cmp++; if (lat !== 1 || a !== 1'b0 || e !== 1'b1) begin n_fail++; $display("FAIL oow_wr: lat %0d ack %b err %b want 1 0 1", lat, a, e); end
    xfer(0, 0, 32'h4, 32'h0, 4'h0, lat, a, e, r);
    n_cmp++; if (r !== 32'h55AA55AA) begin n_fail++; $display("FAIL oow_no_alias: got %h want 55aa55aa", r); end
  endtask

  task automatic test_back_to_back;
    int lat; logic a, e; logic [31:0] r;
    logic [31:0] exp_d [3] = '{32'hA0A0A0A0, 32'h55AA55AA, 32'h0BADF00D};
    xfer(0, 1, 32'h0, 32'hA0A0A0A0, 4'hF, lat, a, e, r);
    xfer(0, 1, 32'h8, 32'h0BADF00D, 4'hF, lat, a, e, r);
    we = 1'b0; addr = 32'h0; set_req(0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_cmp++; if (ack0 !== i[0]) begin n_fail++; $display("FAIL b2b_ack_cycle%0d: got %b want %b", i, ack0, i[0]); end
      if (i[0]) begin
        n_cmp++; if (rd0 !== exp_d[i/2]) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", i/2, rd0, exp_d[i/2]); end
        addr = addr + 32'h4;
      end
    end
    set_req(0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid;
    int lat; logic a, e; logic [31:0] r;
    xfer(1, 1, 32'h48, 32'h13579BDF, 4'hF, lat, a, e, r);
    we = 1'b1; addr = 32'h48; wdata = 32'hFFFFFFFF; sel = 4'hF; set_req(1, 1'b1);
    tick();
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({ack3, err3} !== 2'b00 || rd3 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_clear: ack/err %b data %h want 00 00000000", {ack3, err3}, rd3); end
    rst_n = 1'b1;
    set_req(1, 1'b0);
    tick();
    xfer(1, 0, 32'h48, 32'h0, 4'h0, lat, a, e, r);
    n_cmp++; if (lat !== 4 || a !== 1'b1) begin n_fail++; $display("FAIL rst_mid_retry: lat %0d ack %b want 4 1", lat, a); end
    n_cmp++; if (r !== 32'h13579BDF) begin n_fail++; $display("FAIL rst_mid_data: got %h want 13579bdf", r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait_states();
    test_abort();
    test_out_of_window();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
